// File: rtl/param_reg_checker.sv
// Self-checking stimulus/response block: drives an LCG sequence into a register path
// and checks each response LAT cycles later. Define PARAM_REG_CHECKER_LOG_EN for first-mismatch capture.
module param_reg_checker #(
    parameter int             W     = 8,
    parameter int             N_VEC = 10,
    parameter int             LAT   = 1,
    parameter logic [W-1:0]   SEED  = '0,
    parameter int             CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [W-1:0]  stim,
    input  logic [W-1:0]  resp,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] first_idx,
    output logic [W-1:0]  first_exp,
    output logic [W-1:0]  first_act
);
    localparam int VW = (N_VEC > 1) ? $clog2(N_VEC) : 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [VW-1:0] LAST_VEC   = VW'(N_VEC - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [W-1:0]    stim_q, stim_d;
    logic [CW-1:0]   err_q, err_d, err_upd;
    logic            pass_q, pass_d;
    logic [W-1:0]    exp_q [LAT];
    logic [LAT-1:0]  vld_q;
    logic            mism;

    assign mism    = vld_q[LAT-1] && (resp != exp_q[LAT-1]);
    assign err_upd = (mism && (err_q != '1)) ? err_q + CW'(1) : err_q;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        stim_d  = '0;
        err_d   = err_upd;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    stim_d  = SEED;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (vec_q == LAST_VEC) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    vec_d  = vec_q + VW'(1);
                    stim_d = (stim_q << 2) + stim_q + W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                // Verdict includes any compare landing in this same cycle.
                pass_d  = (err_upd == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            drain_q <= '0;
            stim_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < LAT; i++) exp_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            drain_q  <= drain_d;
            stim_q   <= stim_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            // Prediction shift: stage 0 mirrors what the path sees this cycle.
            vld_q[0] <= (state_q == RUN);
            exp_q[0] <= stim_q;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    assign stim    = stim_q;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign pass    = pass_q;
    assign err_cnt = err_q;

`ifdef PARAM_REG_CHECKER_LOG_EN
    logic [CW-1:0] cidx_q, fidx_q;
    logic [W-1:0]  fexp_q, fact_q;
    logic          seen_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cidx_q <= '0;
            fidx_q <= '0;
            fexp_q <= '0;
            fact_q <= '0;
            seen_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            cidx_q <= '0;
            fidx_q <= '0;
            fexp_q <= '0;
            fact_q <= '0;
            seen_q <= 1'b0;
        end else if (vld_q[LAT-1]) begin
            cidx_q <= cidx_q + CW'(1);
            if (mism && !seen_q) begin
                seen_q <= 1'b1;
                fidx_q <= cidx_q;
                fexp_q <= exp_q[LAT-1];
                fact_q <= resp;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && mism)
            $display("param_reg_checker: vector %0d expected %h got %h", cidx_q, exp_q[LAT-1], resp);
    end
`endif

    assign first_idx = fidx_q;
    assign first_exp = fexp_q;
    assign first_act = fact_q;
`else
    assign first_idx = '0;
    assign first_exp = '0;
    assign first_act = '0;
`endif

endmodule

// File: tb/tb_param_reg_checker.sv
// Bench for param_reg_checker: LAT=1 and LAT=2 instances, table-driven runs,
// hand sequences for reset/restart corners and randomized responses against a reference model.
module tb_param_reg_checker;
    localparam int N = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [7:0]  stim1, resp1, fexp1, fact1;
    logic        busy1, done1, pass1;
    logic [15:0] err1, fidx1;
    logic [7:0]  stim2, resp2, fexp2, fact2;
    logic        busy2, done2, pass2;
    logic [2:0]  err2, fidx2;

    param_reg_checker #(.W(8), .N_VEC(N), .LAT(1), .SEED(8'h00), .CW(16)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stim(stim1), .resp(resp1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_idx(fidx1), .first_exp(fexp1), .first_act(fact1));

    param_reg_checker #(.W(8), .N_VEC(N), .LAT(2), .SEED(8'h00), .CW(3)) dut2 (
        .clk(clk), .reset(reset), .start(start), .stim(stim2), .resp(resp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_idx(fidx2), .first_exp(fexp2), .first_act(fact2));

    // Registers standing in for the path under check.
    logic [7:0] r1a, r1b, r2a, r2b;
    always @(posedge clk) begin
        r1a <= stim1;
        r1b <= r1a;
        r2a <= stim2;
        r2b <= r2a;
    end

    int         path_mode;
    logic [7:0] tab_val;
    bit         force2;
    assign resp1 = (path_mode == 0) ? r1a : (path_mode == 4) ? r1b : tab_val;
    assign resp2 = force2 ? 8'h00 : r2b;

    int checks = 0;
    int failures = 0;

    typedef logic [7:0] tab_t [16];
    tab_t tab;

    typedef struct {
        int         mode;
        int         corrupt;
        int         extra;
        bit         f2;
        int         err;
        bit         pass;
        int         fi;
        logic [7:0] fe;
        logic [7:0] fa;
    } vec_t;
    vec_t vt [5];

    logic [7:0] known [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] lcg(input int k);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < k; i++) v = v * 8'd5 + 8'd1;
        return v;
    endfunction

    // Response seen in cycle c (cycle 1 = first RUN cycle) for each path mode.
    task automatic build_tab(input int mode, input int corrupt);
        for (int c = 0; c < 16; c++) begin
            logic [7:0] e;
            e = (c >= 2 && c <= N + 1) ? lcg(c - 2) : 8'h00;
            case (mode)
                1: tab[c] = 8'h00;
                2: tab[c] = e ^ ((c == corrupt + 2) ? 8'h01 : 8'h00);
                3: tab[c] = (c >= 2 && c <= N + 1 && $urandom_range(0, 1) == 1)
                            ? 8'($urandom_range(0, 255)) : e;
                4: tab[c] = (c >= 3 && c <= N + 2) ? lcg(c - 3) : 8'h00;
                default: tab[c] = e;
            endcase
        end
    endtask

    // Vector k is due back one cycle after issue (cycle k+1), i.e. in cycle k+2.
    task automatic model(output int err, output int fi, output logic [7:0] fe, output logic [7:0] fa);
        bit seen;
        err = 0; fi = 0; fe = 8'h00; fa = 8'h00; seen = 0;
        for (int k = 0; k < N; k++) begin
            if (tab[k + 2] != lcg(k)) begin
                if (!seen) begin
                    seen = 1; fi = k; fe = lcg(k); fa = tab[k + 2];
                end
                if (err < 65535) err++;
            end
        end
    endtask

    task automatic run(input int mode, input int extra, input bit f2, input int e_err,
                       input bit e_pass, input int e_fi, input logic [7:0] e_fe, input logic [7:0] e_fa);
        path_mode = mode;
        force2 = f2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 14; c++) begin
            start = (c == extra);
            tab_val = tab[c];
            @(negedge clk);
            chk($sformatf("stim1 c%0d", c), stim1, (c <= N) ? lcg(c - 1) : 8'h00);
            chk($sformatf("stim2 c%0d", c), stim2, (c <= N) ? lcg(c - 1) : 8'h00);
            chk($sformatf("busy1 c%0d", c), busy1, c <= N + 1);
            chk($sformatf("done1 c%0d", c), done1, c == N + 2);
            chk($sformatf("busy2 c%0d", c), busy2, c <= N + 2);
            chk($sformatf("done2 c%0d", c), done2, c == N + 3);
            if (c == 1) begin
                chk("pass1 cleared at start", pass1, 0);
                chk("err1 cleared at start", err1, 0);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        tab_val = 8'h00;
        chk($sformatf("err1 mode%0d", mode), err1, e_err);
        chk($sformatf("pass1 mode%0d", mode), pass1, e_pass);
        chk($sformatf("err2 f2=%0d", f2), err2, f2 ? 7 : 0);
        chk($sformatf("pass2 f2=%0d", f2), pass2, !f2);
`ifdef PARAM_REG_CHECKER_LOG_EN
        chk("first_idx1", fidx1, e_fi);
        chk("first_exp1", fexp1, e_fe);
        chk("first_act1", fact1, e_fa);
        chk("first_idx2", fidx2, f2 ? 1 : 0);
        chk("first_exp2", fexp2, f2 ? 8'h01 : 8'h00);
        chk("first_act2", fact2, 8'h00);
`else
        chk("first_idx1", fidx1, 0);
        chk("first_exp1", fexp1, 0);
        chk("first_act1", fact1, 0);
        chk("first_idx2", fidx2, 0);
        chk("first_exp2", fexp2, 0);
        chk("first_act2", fact2, 0);
        if (e_fi < 0 || e_fe === 8'hxx || e_fa === 8'hxx) chk("model first fields", 0, 1);
`endif
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_err, m_fi, cyc;
        logic [7:0] m_fe, m_fa;
        bit f2;

        known = '{8'h00, 8'h01, 8'h06, 8'h1F, 8'h9C, 8'h0D, 8'h42, 8'h4B, 8'h78, 8'h59};
        vt[0] = '{0, 0, 0, 1'b0, 0, 1'b1, 0, 8'h00, 8'h00};
        vt[1] = '{1, 0, 0, 1'b1, 9, 1'b0, 1, 8'h01, 8'h00};
        vt[2] = '{2, 3, 0, 1'b0, 1, 1'b0, 3, 8'h1F, 8'h1E};
        vt[3] = '{4, 0, 0, 1'b0, 9, 1'b0, 1, 8'h01, 8'h00};
        vt[4] = '{0, 0, 4, 1'b0, 0, 1'b1, 0, 8'h00, 8'h00};

        reset = 1'b1; start = 1'b0; path_mode = 0; tab_val = 8'h00; force2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stim", stim1, 0);
        chk("reset busy", busy1, 0);
        chk("reset done", done1, 0);
        chk("reset pass", pass1, 0);
        chk("reset err", err1, 0);
        chk("reset first_idx", fidx1, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            build_tab(vt[i].mode, vt[i].corrupt);
            run(vt[i].mode, vt[i].extra, vt[i].f2, vt[i].err, vt[i].pass, vt[i].fi, vt[i].fe, vt[i].fa);
        end

        // Reset while vector 5 is on the stimulus port.
        build_tab(1, 0);
        path_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tab_val = tab[c];
            @(negedge clk);
            chk($sformatf("known stim c%0d", c), stim1, known[c - 1]);
            if (c < 6) begin
                @(posedge clk);
                #1;
            end
        end
        chk("err1 before reset", err1, 3);
        reset = 1'b1;
        #1;
        chk("midrun reset stim", stim1, 0);
        chk("midrun reset busy", busy1, 0);
        chk("midrun reset done", done1, 0);
        chk("midrun reset err", err1, 0);
        chk("midrun reset busy2", busy2, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tab_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        build_tab(0, 0);
        run(0, 0, 0, 0, 1'b1, 0, 8'h00, 8'h00);

        // Start held high across the end of a run.
        path_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk($sformatf("b2b done c%0d", c), done1, c == 12);
            if (c == 13) begin
                chk("b2b idle busy", busy1, 0);
                chk("b2b idle stim", stim1, 0);
            end
            if (c == 14) begin
                chk("b2b restart busy", busy1, 1);
                chk("b2b restart stim", stim1, lcg(0));
            end
            if (c == 15) chk("b2b second stim", stim1, lcg(1));
            @(posedge clk);
            #1;
            if (c == 14) start = 1'b0;
        end
        cyc = 16;
        while (cyc < 40) begin
            @(negedge clk);
            if (done1) break;
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("b2b second done cycle", cyc, 25);
        @(posedge clk);
        @(negedge clk);
        chk("b2b second pass", pass1, 1);
        chk("b2b second err", err1, 0);
        repeat (5) @(posedge clk);
        #1;

        for (int r = 0; r < 6; r++) begin
            build_tab(3, 0);
            model(m_err, m_fi, m_fe, m_fa);
            f2 = ($urandom_range(0, 1) == 1);
            run(3, 0, f2, m_err, m_err == 0, m_fi, m_fe, m_fa);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
